uart_rx: RTL and testbench

Serial receiver for the PC-to-FPGA link: it deserialises 8N1 UART frames arriving on the board `rx` pin and presents each byte as a one-cycle valid/data pulse. It sits directly upstream of the puzzle-loading logic and is the receive-side counterpart of the existing `uart_tx` transmitter, sharing its baud configuration so one host-side serial setting serves both directions.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_ff.sv | 28 ++
 rtl/uart_rx.sv | 125 ++++++++++++
 tb/tb_uart_rx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the common baud
// divisor used by both uart_rx and uart_tx instantiations.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int CLKS_PER_BIT_115200 = 868;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for asynchronous inputs; also reused for buttons.
// Flops reset to RESET_VAL so an idle-high line does not look like activity.
module sync_ff #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {DEPTH{RESET_VAL}};
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples mid-bit, emits a one-cycle axiov/axiod pulse per
// byte and a frame_err pulse on a low stop bit, then waits out any break.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       axiov,
  output logic [7:0] axiod,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             w_rx_s;
  logic             w_half_done;
  logic             w_bit_done;
  rx_state_t        r_state;
  rx_state_t        w_next_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_axiov;
  logic [7:0]       r_axiod;
  logic             r_frame_err;

  sync_ff #(
    .DEPTH    (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (rxd),
    .o_q  (w_rx_s)
  );

  assign w_half_done = (r_baud_cnt == HALF_LAST);
  assign w_bit_done  = (r_baud_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (!w_rx_s) w_next_state = START;
      START: if (w_half_done) w_next_state = w_rx_s ? IDLE : DATA;
      DATA:  if (w_bit_done && (r_bit_idx == 3'd7)) w_next_state = STOP;
      STOP:  if (w_bit_done) w_next_state = w_rx_s ? IDLE : BREAK;
      BREAK: if (w_rx_s) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Counters and output registers; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_axiov     <= 1'b0;
      r_axiod     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_axiov     <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_baud_cnt <= '0;
          r_bit_idx  <= '0;
        end
        START: begin
          r_baud_cnt <= w_half_done ? '0 : r_baud_cnt + 1'b1;
        end
        DATA: begin
          if (w_bit_done) begin
            r_baud_cnt          <= '0;
            r_shift[r_bit_idx]  <= w_rx_s;
            r_bit_idx           <= r_bit_idx + 3'd1;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_done) begin
            r_baud_cnt <= '0;
            if (w_rx_s) begin
              r_axiod <= r_shift;
              r_axiov <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        BREAK: begin
          r_baud_cnt <= '0;
        end
        default: begin
          r_baud_cnt <= '0;
          r_bit_idx  <= '0;
        end
      endcase
    end
  end

  assign axiov     = r_axiov;
  assign axiod     = r_axiod;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks/bit; a scoreboard queue holds the
// bytes each sent frame should deliver, popped when axiov pulses.
module tb_uart_rx;

  localparam int N    = 16;
  localparam int SYNC = 2;
  localparam int H    = N / 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd   = 1'b1;
  logic       axiov;
  logic [7:0] axiod;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cycleCount = 0;
  int axiovCount = 0;
  int frameErrCount = 0;
  bit busySeen = 1'b0;
  logic [7:0] expQ[$];
  int axiovCycles[$];

  int s0, s1, s2, s3, s4, s5, s6;

  uart_rx #(
    .CLKS_PER_BIT(N),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .axiov    (axiov),
    .axiod    (axiod),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int cycleAt(input int idx);
    if (idx < axiovCycles.size()) return axiovCycles[idx];
    return -1;
  endfunction

  // Drives one full frame starting at the current negedge; good frames are queued.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, output int startCycle);
    if (stopBit) expQ.push_back(data);
    startCycle = cycleCount;
    rxd = 1'b0;
    waitCycles(N);
    for (int b = 0; b < 8; b++) begin
      rxd = data[b];
      waitCycles(N);
    end
    rxd = stopBit;
    waitCycles(N);
  endtask

  // Output monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (busy) busySeen = 1'b1;
    if (frame_err) frameErrCount++;
    if (axiov | frame_err) checkOutput("pulse_exclusive", {31'd0, axiov & frame_err}, 32'd0);
    if (axiov) begin
      axiovCount++;
      axiovCycles.push_back(cycleCount);
      checkOutput("axiov_expected", {31'd0, expQ.size() > 0}, 32'd1);
      if (expQ.size() > 0) checkOutput("axiod_scoreboard", {24'd0, axiod}, {24'd0, expQ.pop_front()});
    end
  end

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    waitCycles(3);
    checkOutput("reset_axiov", {31'd0, axiov}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_axiod", {24'd0, axiod}, 32'd0);
    rst_n = 1'b1;

    busySeen = 1'b0;
    waitCycles(500);
    checkOutput("idle_axiov_count", axiovCount, 0);
    checkOutput("idle_frame_err_count", frameErrCount, 0);
    checkOutput("idle_busy_seen", {31'd0, busySeen}, 32'd0);
    checkOutput("idle_axiod", {24'd0, axiod}, 32'd0);

    // axiov is visible in the cycle after the stop-bit sample edge.
    applyStimulus(8'hA5, 1'b1, s0);
    waitCycles(N);
    checkOutput("a5_count", axiovCount, 1);
    checkOutput("a5_timing", cycleAt(0), s0 + SYNC + H + 9 * N + 1);
    checkOutput("a5_axiod", {24'd0, axiod}, 32'h0000_00A5);
    checkOutput("a5_busy_after", {31'd0, busy}, 32'd0);

    applyStimulus(8'h00, 1'b1, s1);
    applyStimulus(8'hFF, 1'b1, s2);
    applyStimulus(8'h3C, 1'b1, s3);
    waitCycles(2 * N);
    checkOutput("b2b_count", axiovCount, 4);
    checkOutput("b2b_first_timing", cycleAt(1), s1 + SYNC + H + 9 * N + 1);
    checkOutput("b2b_spacing_1", cycleAt(2) - cycleAt(1), 10 * N);
    checkOutput("b2b_spacing_2", cycleAt(3) - cycleAt(2), 10 * N);
    checkOutput("b2b_axiod_last", {24'd0, axiod}, 32'h0000_003C);

    rxd = 1'b0;
    waitCycles(4);
    rxd = 1'b1;
    waitCycles(2);
    checkOutput("glitch_busy_mid", {31'd0, busy}, 32'd1);
    waitCycles(20);
    checkOutput("glitch_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("glitch_axiov_count", axiovCount, 4);
    checkOutput("glitch_frame_err_count", frameErrCount, 0);

    applyStimulus(8'h55, 1'b0, s4);
    waitCycles(300);
    checkOutput("ferr_count", frameErrCount, 1);
    checkOutput("ferr_no_axiov", axiovCount, 4);
    checkOutput("ferr_axiod_held", {24'd0, axiod}, 32'h0000_003C);
    checkOutput("ferr_break_busy", {31'd0, busy}, 32'd1);
    rxd = 1'b1;
    waitCycles(5);
    checkOutput("ferr_idle_after_break", {31'd0, busy}, 32'd0);
    applyStimulus(8'h12, 1'b1, s5);
    waitCycles(N);
    checkOutput("ferr_next_count", axiovCount, 5);
    checkOutput("ferr_next_axiod", {24'd0, axiod}, 32'h0000_0012);
    checkOutput("ferr_next_frame_err_count", frameErrCount, 1);

    // Partial frame 0x81: start, bit0=1, bits1..2=0, then reset mid-DATA.
    rxd = 1'b0;
    waitCycles(N);
    rxd = 1'b1;
    waitCycles(N);
    rxd = 1'b0;
    waitCycles(2 * N);
    checkOutput("rst_busy_mid_data", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    rxd   = 1'b1;
    waitCycles(1);
    checkOutput("rst_busy_cleared", {31'd0, busy}, 32'd0);
    checkOutput("rst_axiod_cleared", {24'd0, axiod}, 32'd0);
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(12 * N);
    checkOutput("rst_no_axiov", axiovCount, 5);
    checkOutput("rst_no_frame_err", frameErrCount, 1);
    applyStimulus(8'h7E, 1'b1, s6);
    waitCycles(N);
    checkOutput("post_rst_count", axiovCount, 6);
    checkOutput("post_rst_axiod", {24'd0, axiod}, 32'h0000_007E);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
